// File: rtl/cache_pkg.sv
// Shared cache controller types: FSM state encoding and bus direction constants.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVICT,
    FILL,
    FILL_DONE,
    WT
  } state_t;

  // Bus/processor direction encoding, shared with the datapath.
  localparam logic CREAD  = 1'b1;
  localparam logic CWRITE = 1'b0;

endpackage

// File: rtl/burst_ctr.sv
// Beat counter for line fill / evict bursts. Wraps naturally at LINE_WORDS
// (power of two), so the last increment of a burst returns it to word 0.
module burst_ctr #(
  parameter  int LINE_WORDS = 4,
  localparam int BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);

  // Beat index: cleared on reset/clr, advanced once per accepted beat.
  always_ff @(posedge clk) begin
    if (rst || clr)
      beat <= '0;
    else if (inc)
      beat <= beat + BEAT_W'(1);
  end

  assign last = (beat == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_ctrl_burst.sv
// Cache control FSM with burst line fill, dirty-victim eviction and per-beat
// system bus handshake. Drives tag/data array strobes and selects; the data
// muxes themselves live in the datapath.
module cache_ctrl_burst
  import cache_pkg::*;
#(
  parameter  int LINE_WORDS = 4,
  parameter  bit WRITE_BACK = 1'b1,
  localparam int BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_strobe,
  input  logic              p_rw,
  output logic              p_ready,
  input  logic              hit,
  input  logic              dirty,
  output logic              data_we,
  output logic              fill_sel,
  output logic              tag_we,
  output logic              dirty_set,
  output logic [BEAT_W-1:0] word_sel,
  output logic              victim_sel,
  output logic              s_strobe,
  output logic              s_rw,
  input  logic              s_ready
);

  state_t            state, state_nxt;
  logic              rw_q;
  logic [BEAT_W-1:0] beat;
  logic              last;
  logic              beat_inc;
  logic              beat_clr;

  // Beat counter held at zero whenever the FSM is idle.
  assign beat_clr = (state == IDLE);

  burst_ctr #(.LINE_WORDS(LINE_WORDS)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (beat_clr),
    .inc  (beat_inc),
    .beat (beat),
    .last (last)
  );

  // State register and request direction latched on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rw_q  <= CREAD;
    end else begin
      state <= state_nxt;
      if (state == IDLE && p_strobe)
        rw_q <= p_rw;
    end
  end

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_nxt  = state;
    beat_inc   = 1'b0;
    p_ready    = 1'b0;
    data_we    = 1'b0;
    fill_sel   = 1'b0;
    tag_we     = 1'b0;
    dirty_set  = 1'b0;
    word_sel   = '0;
    victim_sel = 1'b0;
    s_strobe   = 1'b0;
    s_rw       = 1'b0;
    case (state)
      IDLE: begin
        if (p_strobe)
          state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          if (rw_q == CREAD) begin
            p_ready   = 1'b1;
            state_nxt = IDLE;
          end else begin
            data_we = 1'b1;
            if (WRITE_BACK) begin
              dirty_set = 1'b1;
              p_ready   = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = WT;
            end
          end
        end else if (WRITE_BACK && dirty) begin
          state_nxt = EVICT;
        end else if (rw_q == CREAD || WRITE_BACK) begin
          state_nxt = FILL;
        end else begin
          // write-through miss: no allocation, just forward the write
          state_nxt = WT;
        end
      end
      EVICT: begin
        s_strobe   = 1'b1;
        s_rw       = CWRITE;
        victim_sel = 1'b1;
        word_sel   = beat;
        if (s_ready) begin
          beat_inc = 1'b1;
          if (last)
            state_nxt = FILL;
        end
      end
      FILL: begin
        s_strobe = 1'b1;
        s_rw     = CREAD;
        fill_sel = 1'b1;
        word_sel = beat;
        data_we  = s_ready;
        if (s_ready) begin
          beat_inc = 1'b1;
          if (last)
            state_nxt = FILL_DONE;
        end
      end
      FILL_DONE: begin
        tag_we    = 1'b1;
        p_ready   = 1'b1;
        state_nxt = IDLE;
        // write-allocate: merge the processor word after the refill
        if (WRITE_BACK && rw_q == CWRITE) begin
          data_we   = 1'b1;
          dirty_set = 1'b1;
        end
      end
      WT: begin
        s_strobe = 1'b1;
        s_rw     = CWRITE;
        if (s_ready) begin
          p_ready   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Bench for cache_ctrl_burst: write-back instance driven by a scoreboard
// monitor, plus a write-through instance exercised cycle by cycle.
module tb_cache_ctrl_burst;
  import cache_pkg::*;

  typedef struct packed {logic fs; logic [1:0] ws; logic ds;} we_t;
  typedef struct packed {logic rw; logic vs; logic [1:0] ws;} beat_t;
  typedef struct packed {int lat; logic tw;} done_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p_strobe = 1'b0, p_rw = CREAD, hit = 1'b0, dirty = 1'b0, s_ready = 1'b0;
  logic       p_ready, data_we, fill_sel, tag_we, dirty_set, victim_sel, s_strobe, s_rw;
  logic [1:0] word_sel;

  logic       p_strobe_wt = 1'b0, p_rw_wt = CREAD, hit_wt = 1'b0, s_ready_wt = 1'b0;
  logic       p_ready_wt, data_we_wt, fill_sel_wt, tag_we_wt, dirty_set_wt, victim_sel_wt;
  logic       s_strobe_wt, s_rw_wt;
  logic [1:0] word_sel_wt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_strobe = 0;
  int rcnt  = 0;
  localparam int LAT = 2;

  we_t   exp_we[$];
  beat_t exp_beat[$];
  done_t exp_done[$];
  we_t   ew;
  beat_t eb;
  done_t ed;
  logic  prev_pr = 1'b0;

  cache_ctrl_burst #(.LINE_WORDS(4), .WRITE_BACK(1'b1)) u_wb (
    .clk(clk), .rst(rst), .p_strobe(p_strobe), .p_rw(p_rw), .p_ready(p_ready),
    .hit(hit), .dirty(dirty), .data_we(data_we), .fill_sel(fill_sel), .tag_we(tag_we),
    .dirty_set(dirty_set), .word_sel(word_sel), .victim_sel(victim_sel),
    .s_strobe(s_strobe), .s_rw(s_rw), .s_ready(s_ready)
  );

  cache_ctrl_burst #(.LINE_WORDS(4), .WRITE_BACK(1'b0)) u_wt (
    .clk(clk), .rst(rst), .p_strobe(p_strobe_wt), .p_rw(p_rw_wt), .p_ready(p_ready_wt),
    .hit(hit_wt), .dirty(1'b0), .data_we(data_we_wt), .fill_sel(fill_sel_wt), .tag_we(tag_we_wt),
    .dirty_set(dirty_set_wt), .word_sel(word_sel_wt), .victim_sel(victim_sel_wt),
    .s_strobe(s_strobe_wt), .s_rw(s_rw_wt), .s_ready(s_ready_wt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // System bus slave for the write-back instance: one beat every LAT cycles.
  always @(posedge clk) begin
    #2;
    if (rst || !s_strobe) begin
      s_ready = 1'b0;
      rcnt    = 0;
    end else if (rcnt == LAT - 1) begin
      s_ready = 1'b1;
      rcnt    = 0;
    end else begin
      s_ready = 1'b0;
      rcnt++;
    end
  end

  // Scoreboard monitor: array writes, bus beats and completions.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_we) begin
        total++;
        if (exp_we.size() == 0) begin
          bad++;
          $display("FAIL data_we_unexpected got ws=%0d fs=%0d ds=%0d", word_sel, fill_sel, dirty_set);
        end else begin
          ew = exp_we.pop_front();
          if ({fill_sel, word_sel, dirty_set} !== ew) begin
            bad++;
            $display("FAIL data_we got fs/ws/ds=%b %0d %b want %b %0d %b",
                     fill_sel, word_sel, dirty_set, ew.fs, ew.ws, ew.ds);
          end
        end
      end
      if (s_strobe && s_ready) begin
        total++;
        if (exp_beat.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got rw=%b ws=%0d", s_rw, word_sel);
        end else begin
          eb = exp_beat.pop_front();
          if ({s_rw, victim_sel, word_sel} !== eb) begin
            bad++;
            $display("FAIL beat got rw/vs/ws=%b %b %0d want %b %b %0d",
                     s_rw, victim_sel, word_sel, eb.rw, eb.vs, eb.ws);
          end
        end
      end
      if (p_ready) begin
        total++;
        if (prev_pr) begin
          bad++;
          $display("FAIL p_ready_consecutive got 1 want 0 at cycle %0d", cyc);
        end
        total++;
        if (exp_done.size() == 0) begin
          bad++;
          $display("FAIL p_ready_unexpected at latency %0d", cyc - t_strobe);
        end else begin
          ed = exp_done.pop_front();
          if ((cyc - t_strobe) !== ed.lat || tag_we !== ed.tw) begin
            bad++;
            $display("FAIL done got lat=%0d tag_we=%b want lat=%0d tag_we=%b",
                     cyc - t_strobe, tag_we, ed.lat, ed.tw);
          end
        end
      end
    end
    prev_pr = p_ready && !rst;
  end

  task automatic drive_req(input logic rw, input logic h, input logic d);
    @(posedge clk); #1;
    p_strobe = 1'b1; p_rw = rw; hit = h; dirty = d;
    t_strobe = cyc;
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    p_strobe = 1'b0; hit = 1'b0; dirty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({p_ready, data_we, fill_sel, tag_we, dirty_set, word_sel, victim_sel, s_strobe, s_rw} !== 10'b0) begin
      bad++;
      $display("FAIL reset_wb got %b want 0",
               {p_ready, data_we, fill_sel, tag_we, dirty_set, word_sel, victim_sel, s_strobe, s_rw});
    end
    total++;
    if ({p_ready_wt, data_we_wt, fill_sel_wt, tag_we_wt, dirty_set_wt, word_sel_wt,
         victim_sel_wt, s_strobe_wt, s_rw_wt} !== 10'b0) begin
      bad++;
      $display("FAIL reset_wt got %b want 0", {p_ready_wt, data_we_wt, fill_sel_wt, tag_we_wt,
               dirty_set_wt, word_sel_wt, victim_sel_wt, s_strobe_wt, s_rw_wt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_read_hit();
    int ns = 0;
    logic got = 1'b0;
    exp_done.push_back('{lat: 1, tw: 1'b0});
    drive_req(CREAD, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_strobe) ns++;
      if (p_ready) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL read_hit_timeout got none want p_ready"); end
    total++;
    if (ns !== 0) begin bad++; $display("FAIL read_hit_s_strobe got %0d want 0", ns); end
    drop_req();
  endtask

  task automatic test_read_miss(input int lat);
    int ntag = 0;
    logic got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_we.push_back('{fs: 1'b1, ws: 2'(i), ds: 1'b0});
      exp_beat.push_back('{rw: CREAD, vs: 1'b0, ws: 2'(i)});
    end
    exp_done.push_back('{lat: lat, tw: 1'b1});
    drive_req(CREAD, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (tag_we) ntag++;
      if (p_ready) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL read_miss_timeout got none want p_ready"); end
    total++;
    if (ntag !== 1) begin bad++; $display("FAIL read_miss_tag_we got %0d want 1", ntag); end
    drop_req();
  endtask

  task automatic test_write_miss_dirty();
    logic got = 1'b0;
    for (int i = 0; i < 4; i++) exp_beat.push_back('{rw: CWRITE, vs: 1'b1, ws: 2'(i)});
    for (int i = 0; i < 4; i++) begin
      exp_beat.push_back('{rw: CREAD, vs: 1'b0, ws: 2'(i)});
      exp_we.push_back('{fs: 1'b1, ws: 2'(i), ds: 1'b0});
    end
    exp_we.push_back('{fs: 1'b0, ws: 2'd0, ds: 1'b1});
    exp_done.push_back('{lat: 18, tw: 1'b1});
    drive_req(CWRITE, 1'b0, 1'b1);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (p_ready) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL write_miss_timeout got none want p_ready"); end
    drop_req();
  endtask

  task automatic test_wb_write_hit();
    logic got = 1'b0;
    exp_we.push_back('{fs: 1'b0, ws: 2'd0, ds: 1'b1});
    exp_done.push_back('{lat: 1, tw: 1'b0});
    drive_req(CWRITE, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p_ready) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL wb_write_hit_timeout got none want p_ready"); end
    drop_req();
  endtask

  task automatic test_reset_mid_fill();
    logic seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_we.push_back('{fs: 1'b1, ws: 2'(i), ds: 1'b0});
      exp_beat.push_back('{rw: CREAD, vs: 1'b0, ws: 2'(i)});
    end
    drive_req(CREAD, 1'b0, 1'b0);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (s_strobe && word_sel == 2'd2) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_fill_timeout got none want beat 2"); end
    rst = 1'b1; p_strobe = 1'b0; hit = 1'b0;
    @(negedge clk);
    total++;
    if ({p_ready, data_we, fill_sel, tag_we, dirty_set, word_sel, victim_sel, s_strobe, s_rw} !== 10'b0) begin
      bad++;
      $display("FAIL mid_fill_reset got %b want 0",
               {p_ready, data_we, fill_sel, tag_we, dirty_set, word_sel, victim_sel, s_strobe, s_rw});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    test_read_miss(10);
  endtask

  task automatic test_back_to_back();
    int np = 0;
    for (int i = 0; i < 3; i++) exp_done.push_back('{lat: 2 * i + 1, tw: 1'b0});
    drive_req(CREAD, 1'b1, 1'b0);
    for (int i = 0; i < 20 && np < 3; i++) begin
      @(negedge clk);
      if (p_ready) np++;
    end
    drop_req();
    total++;
    if (np !== 3) begin bad++; $display("FAIL back_to_back_pulses got %0d want 3", np); end
  endtask

  task automatic test_wt_hit();
    logic [5:0] got, want;
    @(posedge clk); #1;
    p_strobe_wt = 1'b1; p_rw_wt = CWRITE; hit_wt = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      s_ready_wt = (c == 4);
      @(negedge clk);
      got = {data_we_wt, fill_sel_wt, s_strobe_wt, s_rw_wt, p_ready_wt, dirty_set_wt};
      if (c == 1)      want = 6'b100000;
      else if (c == 4) want = {3'b001, CWRITE, 2'b10};
      else             want = {3'b001, CWRITE, 2'b00};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wt_hit_cycle%0d got %b want %b (we,fs,sstb,srw,prdy,dset)", c, got, want);
      end
    end
    @(posedge clk); #1;
    p_strobe_wt = 1'b0; s_ready_wt = 1'b0; hit_wt = 1'b0;
    @(negedge clk);
    total++;
    if ({s_strobe_wt, p_ready_wt, dirty_set_wt} !== 3'b000) begin
      bad++;
      $display("FAIL wt_hit_idle got %b want 000", {s_strobe_wt, p_ready_wt, dirty_set_wt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss(10);
    test_write_miss_dirty();
    test_wb_write_hit();
    test_reset_mid_fill();
    test_back_to_back();
    test_wt_hit();
    repeat (3) @(posedge clk);
    total++;
    if (exp_we.size() != 0 || exp_beat.size() != 0 || exp_done.size() != 0) begin
      bad++;
      $display("FAIL leftover got we=%0d beat=%0d done=%0d want 0 0 0",
               exp_we.size(), exp_beat.size(), exp_done.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
